// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with a 50% duty output for any divisor N >= 2.
// Odd divisors get their half-cycle resolution from a falling-edge copy of the phase flop.
// Also provides a source-domain tick at the start of each output period.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | output parked low, pending divisor applied at once
// RUN   | counting periods, divisor changes only at period boundary
module clk_div_prog #(
    parameter int DIV_W    = 8,
    parameter int DIV_INIT = 5
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic             pend_o,
    output logic             err_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_INIT);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] n_q, n_d;
    logic [DIV_W-1:0] p_q, p_d;
    logic             pend_q, pend_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             clk_p_q, clk_p_d;
    logic             clk_n_q, clk_n_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic             load_ok;
    logic             load_bad;
    logic             pend_eff;
    logic [DIV_W-1:0] p_eff;
    logic [DIV_W-1:0] high_cnt;
    logic [DIV_W-1:0] cnt_inc;
    logic             at_bound;

    // Load qualification and period arithmetic; a load in the boundary cycle bypasses straight in.
    always_comb begin
        load_ok  = load_i && (div_i >= TWO);
        load_bad = load_i && (div_i < TWO);
        pend_eff = pend_q || load_ok;
        p_eff    = load_ok ? div_i : p_q;
        // Shift-then-add keeps the high count inside DIV_W bits even for the largest divisor.
        high_cnt = (n_q >> 1) + {{(DIV_W-1){1'b0}}, n_q[0]};
        cnt_inc  = cnt_q + ONE;
        at_bound = (cnt_q == (n_q - ONE));
    end

    // Next-state, counter, phase and divisor update.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        p_d     = p_eff;
        pend_d  = pend_eff;
        cnt_d   = cnt_q;
        clk_p_d = clk_p_q;
        tick_d  = 1'b0;
        err_d   = load_bad;

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                clk_p_d = 1'b0;
                if (pend_eff) begin
                    n_d = p_eff;
                end
                pend_d = 1'b0;
                if (en_i) begin
                    state_d = RUN;
                    clk_p_d = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            RUN: begin
                if (at_bound) begin
                    cnt_d = '0;
                    if (!en_i) begin
                        // Stop only here so the final period is never truncated.
                        state_d = IDLE;
                        clk_p_d = 1'b0;
                    end else begin
                        // First cycle of a period is always high since H >= 1.
                        clk_p_d = 1'b1;
                        tick_d  = 1'b1;
                        if (pend_eff) begin
                            n_d    = p_eff;
                            pend_d = 1'b0;
                        end
                    end
                end else begin
                    cnt_d   = cnt_inc;
                    clk_p_d = (cnt_inc < high_cnt);
                end
            end
            default: begin
                state_d = IDLE;
                clk_p_d = 1'b0;
            end
        endcase
    end

    // Rising-edge registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= DIV_RST;
            p_q     <= DIV_RST;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            clk_p_q <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            p_q     <= p_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            clk_p_q <= clk_p_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

    // Half-cycle delayed copy of the phase flop, used to trim odd-divisor high time.
    always_comb begin
        clk_n_d = clk_p_q;
    end

    // Falling-edge flop; reset is sampled on the falling edge as well.
    always_ff @(negedge clk_i) begin
        if (!rst_n) begin
            clk_n_q <= 1'b0;
        end else begin
            clk_n_q <= clk_n_d;
        end
    end

    // Odd N: AND with the delayed copy drops the first half cycle of the high phase.
    always_comb begin
        clk_o = n_q[0] ? (clk_p_q & clk_n_q) : clk_p_q;
    end

    assign tick_o = tick_q;
    assign pend_o = pend_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Testbench for clk_div_prog: directed scenarios plus random traffic, checked against a
// period-level reference model that predicts the output in half-cycle slots.
module tb_clk_div_prog;

    localparam int DIV_W    = 8;
    localparam int DIV_INIT = 5;

    logic             clk_i  = 1'b0;
    logic             rst_n  = 1'b0;
    logic             en_i   = 1'b0;
    logic             load_i = 1'b0;
    logic [DIV_W-1:0] div_i  = '0;
    logic             clk_o;
    logic             tick_o;
    logic             pend_o;
    logic             err_o;

    clk_div_prog #(
        .DIV_W    (DIV_W),
        .DIV_INIT (DIV_INIT)
    ) dut (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .en_i   (en_i),
        .load_i (load_i),
        .div_i  (div_i),
        .clk_o  (clk_o),
        .tick_o (tick_o),
        .pend_o (pend_o),
        .err_o  (err_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: a period is (start edge, divisor); the output is derived from the
    // slot offset within that period, not from any counter.
    int m_run   = 0;
    int m_n     = DIV_INIT;
    int m_p     = DIV_INIT;
    int m_pend  = 0;
    int m_start = 0;
    int m_pn    = DIV_INIT;
    int m_have  = 0;
    int m_tick  = 0;
    int m_err   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic begin_period();
        if (m_pend != 0) begin
            m_n    = m_p;
            m_pend = 0;
        end
        m_start = cyc;
        m_pn    = m_n;
        m_tick  = 1;
        m_have  = 1;
    endtask

    task automatic model_edge();
        int good;
        good = (load_i && int'(div_i) >= 2) ? 1 : 0;
        if (!rst_n) begin
            m_run  = 0;
            m_n    = DIV_INIT;
            m_p    = DIV_INIT;
            m_pend = 0;
            m_have = 0;
            m_tick = 0;
            m_err  = 0;
            return;
        end
        m_err  = (load_i && int'(div_i) < 2) ? 1 : 0;
        m_tick = 0;
        if (good != 0) begin
            m_p    = int'(div_i);
            m_pend = 1;
        end
        if (m_run != 0) begin
            if (cyc - m_start == m_pn) begin
                if (en_i) begin
                    begin_period();
                end else begin
                    m_run = 0;
                end
            end
        end else begin
            if (m_pend != 0) begin
                m_n    = m_p;
                m_pend = 0;
            end
            if (en_i) begin
                m_run = 1;
                begin_period();
            end
        end
    endtask

    // Slot 2k is the half after rising edge k, slot 2k+1 the half after the falling edge.
    // Even N is high for offsets [0,N); odd N for [1,N] (starts half a cycle late).
    function automatic int exp_clk(input int slot);
        int h;
        if (m_have == 0) return 0;
        h = slot - 2 * m_start;
        if (h < 0 || h >= 2 * m_pn) return 0;
        if ((m_pn % 2) != 0) return (h >= 1 && h <= m_pn) ? 1 : 0;
        return (h < m_pn) ? 1 : 0;
    endfunction

    task automatic cycle();
        @(posedge clk_i);
        cyc++;
        model_edge();
        #1;
        check_eq("tick", int'(tick_o), m_tick);
        check_eq("pend", int'(pend_o), m_pend);
        check_eq("err", int'(err_o), m_err);
        check_eq("clk_rise_half", int'(clk_o), exp_clk(2 * cyc));
        @(negedge clk_i);
        #1;
        check_eq("clk_fall_half", int'(clk_o), exp_clk(2 * cyc + 1));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input int v);
        load_i = 1'b1;
        div_i  = DIV_W'(v);
        cycle();
        load_i = 1'b0;
    endtask

    // Advance until the model says the active period has divisor n and the state
    // just after the last edge is offset pos into it.
    task automatic wait_pos(input int n, input int pos);
        for (int i = 0; i < 3000; i++) begin
            if (m_run != 0 && m_pn == n && cyc - m_start == pos) return;
            cycle();
        end
        check_eq("wait_timeout", cyc - m_start, pos);
    endtask

    int sweep_vals[6] = '{2, 3, 4, 7, 8, 255};

    initial begin
        // Reset held with en high: everything must read 0.
        rst_n = 1'b0;
        en_i  = 1'b1;
        run(3);
        rst_n = 1'b1;
        run(30);

        // Divisor sweep, four periods each after the switch.
        foreach (sweep_vals[k]) begin
            int old_n;
            old_n = m_pn;
            do_load(sweep_vals[k]);
            run(old_n + 4 * sweep_vals[k] + 2);
        end

        // Load 3 mid-period of N = 8.
        do_load(8);
        wait_pos(8, 2);
        do_load(3);
        run(8 + 12);

        // Load 3 in the boundary cycle of N = 8: bypass, pend never rises.
        do_load(8);
        wait_pos(8, 7);
        do_load(3);
        run(12);

        // Rejected loads, then back-to-back good loads.
        do_load(0);
        run(4);
        do_load(1);
        run(6);
        do_load(6);
        do_load(9);
        run(30);

        // Stop at cnt = 1 with N = 6, then restart.
        do_load(6);
        wait_pos(6, 1);
        en_i = 1'b0;
        run(15);
        en_i = 1'b1;
        run(20);

        // Reset while clk_o is high with N = 5 and a pending load of 9.
        do_load(5);
        wait_pos(5, 0);
        do_load(9);
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(25);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            int r;
            en_i   = ($urandom_range(0, 15) != 0);
            rst_n  = ($urandom_range(0, 499) != 0);
            load_i = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 9);
            if (r == 0)      div_i = DIV_W'($urandom_range(0, 1));
            else if (r == 1) div_i = DIV_W'(255);
            else             div_i = DIV_W'($urandom_range(2, 12));
            cycle();
        end
        load_i = 1'b0;
        rst_n  = 1'b1;
        run(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
